// File: rtl/sin_cos_dco_multi.sv
// Time-multiplexed N-channel sine/cosine DCO.
// One channel slot per enabled clock, round-robin. Each channel keeps its own
// phase accumulator, increment and offset; all channels share one sin/cos
// table, and a channel/valid delay line tags every sample leaving the table.

module sin_cos_table_4096_13bit #(
    parameter int LATENCY = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [11:0]        i_addr,
    output logic signed [12:0] o_sin,
    output logic signed [12:0] o_cos
);
    // Quarter-wave polynomial sin(pi/2 * t), t in Q10, coefficients in Q16.
    // The coefficients sum to exactly 1.0, so the peak lands on 4095.
    localparam logic signed [47:0] A1 = 48'sd102918;
    localparam logic signed [47:0] A3 = -48'sd42120;
    localparam logic signed [47:0] A5 = 48'sd4738;

    function automatic logic signed [12:0] sat_amp(input logic signed [47:0] v);
        if (v > 48'sd4095)
            return 13'sd4095;
        else if (v < 48'sd0)
            return 13'sd0;
        else
            return v[12:0];
    endfunction

    function automatic logic signed [12:0] quarter_sine(input logic [10:0] q);
        logic signed [47:0] t;
        logic signed [47:0] t2;
        logic signed [47:0] inner;
        logic signed [47:0] mid;
        logic signed [47:0] y;
        logic signed [47:0] scaled;
        t      = 48'(q);
        t2     = (t * t) >>> 10;
        inner  = A3 + ((A5 * t2) >>> 10);
        mid    = A1 + ((inner * t2) >>> 10);
        y      = (mid * t) >>> 10;
        scaled = (y * 48'sd4095 + 48'sd32768) >>> 16;
        return sat_amp(scaled);
    endfunction

    // Fold the 4096-point circle onto one quarter wave; bit 11 gives the sign.
    function automatic logic signed [12:0] sine_at(input logic [11:0] a);
        logic [10:0]        q;
        logic signed [12:0] m;
        q = a[10] ? (11'd1024 - {1'b0, a[9:0]}) : {1'b0, a[9:0]};
        m = quarter_sine(q);
        return a[11] ? -m : m;
    endfunction

    logic signed [12:0] w_sin;
    logic signed [12:0] w_cos;
    logic signed [12:0] r_sin_p [LATENCY];
    logic signed [12:0] r_cos_p [LATENCY];

    assign w_sin = sine_at(i_addr);
    assign w_cos = sine_at(i_addr + 12'd1024);

    // Table pipeline; only the output stage is cleared so outputs read 0 after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sin_p[LATENCY-1] <= '0;
            r_cos_p[LATENCY-1] <= '0;
        end else if (CE) begin
            r_sin_p[0] <= w_sin;
            r_cos_p[0] <= w_cos;
            for (int i = 1; i < LATENCY; i++) begin
                r_sin_p[i] <= r_sin_p[i-1];
                r_cos_p[i] <= r_cos_p[i-1];
            end
        end
    end

    assign o_sin = r_sin_p[LATENCY-1];
    assign o_cos = r_cos_p[LATENCY-1];
endmodule

module sin_cos_dco_multi #(
    parameter int CHANNELS      = 4,
    parameter int CH_BITS       = 2,
    parameter int PHASE_BITS    = 32,
    parameter int DATA_WIDTH    = 13,
    parameter int ADDR_WIDTH    = 12,
    parameter int TABLE_LATENCY = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CE,
    input  logic                         WR_EN,
    input  logic [CH_BITS-1:0]           WR_CH,
    input  logic [1:0]                   WR_SEL,
    input  logic [PHASE_BITS-1:0]        WR_DATA,
    input  logic                         SYNC_ALL,
    output logic signed [DATA_WIDTH-1:0] SIN_VALUE,
    output logic signed [DATA_WIDTH-1:0] COS_VALUE,
    output logic [CH_BITS-1:0]           OUT_CH,
    output logic                         OUT_VALID
);
    logic [CH_BITS-1:0]    r_seq;
    logic [PHASE_BITS-1:0] r_phase [CHANNELS];
    logic [PHASE_BITS-1:0] r_inc   [CHANNELS];
    logic [PHASE_BITS-1:0] r_off   [CHANNELS];
    logic [CHANNELS-1:0]   r_pclr;

    logic [ADDR_WIDTH-1:0] r_addr_p0;
    logic                  r_vld_p [TABLE_LATENCY+1];
    logic [CH_BITS-1:0]    r_ch_p  [TABLE_LATENCY+1];

    logic [PHASE_BITS-1:0] w_slot_phase;
    logic [PHASE_BITS-1:0] w_slot_sum;
    logic [CH_BITS-1:0]    w_seq_next;

    // A pending clear makes the slot behave as if the phase were already 0.
    assign w_slot_phase = r_pclr[r_seq] ? '0 : r_phase[r_seq];
    assign w_slot_sum   = w_slot_phase + r_off[r_seq];
    assign w_seq_next   = (r_seq == CH_BITS'(CHANNELS - 1)) ? '0 : r_seq + 1'b1;

    // Sequencer, per-channel accumulators and register bank. Register writes
    // come last so they win over the slot/sync updates on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_seq  <= '0;
            r_pclr <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= '0;
                r_inc[c]   <= '0;
                r_off[c]   <= '0;
            end
        end else if (CE) begin
            if (SYNC_ALL) begin
                r_seq  <= '0;
                r_pclr <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    r_phase[c] <= '0;
            end else begin
                r_seq          <= w_seq_next;
                r_phase[r_seq] <= w_slot_phase + r_inc[r_seq];
                r_pclr[r_seq]  <= 1'b0;
            end
            if (WR_EN && (int'(WR_CH) < CHANNELS)) begin
                case (WR_SEL)
                    2'b00:   r_inc[WR_CH]  <= WR_DATA;
                    2'b01:   r_off[WR_CH]  <= WR_DATA;
                    2'b10:   r_pclr[WR_CH] <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Slot stage: table address from the pre-update phase plus offset.
    always_ff @(posedge CLK) begin
        if (CE)
            r_addr_p0 <= w_slot_sum[PHASE_BITS-1 -: ADDR_WIDTH];
    end

    // Channel/valid delay line, matched to address register plus table latency.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i <= TABLE_LATENCY; i++) begin
                r_vld_p[i] <= 1'b0;
                r_ch_p[i]  <= '0;
            end
        end else if (CE) begin
            r_vld_p[0] <= 1'b1;
            r_ch_p[0]  <= r_seq;
            for (int i = 1; i <= TABLE_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
                r_ch_p[i]  <= r_ch_p[i-1];
            end
        end
    end

    sin_cos_table_4096_13bit #(
        .LATENCY (TABLE_LATENCY)
    ) u_table (
        .CLK    (CLK),
        .RESET  (RESET),
        .CE     (CE),
        .i_addr (r_addr_p0),
        .o_sin  (SIN_VALUE),
        .o_cos  (COS_VALUE)
    );

    assign OUT_VALID = r_vld_p[TABLE_LATENCY];
    assign OUT_CH    = r_ch_p[TABLE_LATENCY];
endmodule
